// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//
// Sequence per operation: IDLE (sample requests, pick winner, latch operands)
// -> EXEC (drive latched operands to the ALU, one-cycle grant to the winner)
// -> DONE (registered result valid for one cycle) -> IDLE.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req0/req1              operation requests, held high until granted
//   a0,b0,op0,cin0,s0      requester 0 operands, opcode, carry-in, flag-update
//   a1,b1,op1,cin1,s1      requester 1 operands, opcode, carry-in, flag-update
//   gnt0/gnt1              one-cycle grant pulse (high during EXEC)
//   alu_a,alu_b,alu_op,
//   alu_cin                operands to the shared ALU (zero outside EXEC)
//   alu_res,alu_cout,
//   alu_zero,alu_neg       combinational ALU outputs
//   res,res_id,err         registered result, owner and invalid-opcode flag
//   res_valid              one-cycle pulse qualifying res/res_id/err
//   flag_n,flag_z,flag_c   architectural NZC flags
//   busy                   high whenever not IDLE
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       op0,
    input  logic [3:0]       op1,
    input  logic             cin0,
    input  logic             cin1,
    input  logic             s0,
    input  logic             s1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             res_id,
    output logic             err,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;

    logic [1:0]       state_q, state_d;
    logic             last_id_q;
    logic [WIDTH-1:0] lat_a_q, lat_b_q;
    logic [3:0]       lat_op_q;
    logic             lat_cin_q, lat_s_q, lat_id_q;
    logic [WIDTH-1:0] res_q;
    logic             res_id_q, err_q;
    logic             flag_n_q, flag_z_q, flag_c_q;

    logic any_req;
    logic win_id;
    logic op_valid;

    always_comb begin
        any_req = req0 | req1;
        // On a tie the requester that did not win last time goes next.
        win_id  = (req0 & req1) ? ~last_id_q : req1;
        op_valid = (lat_op_q == OP_AND) || (lat_op_q == OP_SUB) || (lat_op_q == OP_ADD);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = any_req ? EXEC : IDLE;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;
            lat_a_q   <= '0;
            lat_b_q   <= '0;
            lat_op_q  <= '0;
            lat_cin_q <= 1'b0;
            lat_s_q   <= 1'b0;
            lat_id_q  <= 1'b0;
            res_q     <= '0;
            res_id_q  <= 1'b0;
            err_q     <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                lat_a_q   <= win_id ? a1 : a0;
                lat_b_q   <= win_id ? b1 : b0;
                lat_op_q  <= win_id ? op1 : op0;
                lat_cin_q <= win_id ? cin1 : cin0;
                lat_s_q   <= win_id ? s1 : s0;
                lat_id_q  <= win_id;
                last_id_q <= win_id;
            end
            if (state_q == EXEC) begin
                res_q    <= op_valid ? alu_res : '0;
                res_id_q <= lat_id_q;
                err_q    <= ~op_valid;
                if (lat_s_q && op_valid) begin
                    flag_n_q <= alu_neg;
                    flag_z_q <= alu_zero;
                    // AND has no meaningful carry, so C is cleared.
                    flag_c_q <= (lat_op_q == OP_AND) ? 1'b0 : alu_cout;
                end
            end
        end
    end

    always_comb begin
        gnt0      = (state_q == EXEC) && !lat_id_q;
        gnt1      = (state_q == EXEC) && lat_id_q;
        alu_a     = (state_q == EXEC) ? lat_a_q : '0;
        alu_b     = (state_q == EXEC) ? lat_b_q : '0;
        alu_op    = (state_q == EXEC) ? lat_op_q : 4'b0000;
        alu_cin   = (state_q == EXEC) ? lat_cin_q : 1'b0;
        res       = res_q;
        res_valid = (state_q == DONE);
        res_id    = res_id_q;
        err       = err_q;
        flag_n    = flag_n_q;
        flag_z    = flag_z_q;
        flag_c    = flag_c_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [3:0]       op0, op1;
    logic             cin0, cin1, s0, s1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_op;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout, alu_zero, alu_neg;
    logic [WIDTH-1:0] res;
    logic             res_valid, res_id, err;
    logic             flag_n, flag_z, flag_c, busy;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .cin0(cin0), .cin1(cin1), .s0(s0), .s1(s1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .res(res), .res_valid(res_valid), .res_id(res_id), .err(err),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
    );

    // Reference ALU: SUB computes a + ~b + cin (carry = no borrow).
    // Undefined opcodes return a|b with carry set so a wrongful update is visible.
    logic [WIDTH:0] sum;
    always_comb begin
        sum      = '0;
        alu_res  = '0;
        alu_cout = 1'b0;
        case (alu_op)
            4'b0000: alu_res = alu_a & alu_b;
            4'b0010: begin
                sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, alu_cin};
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
            end
            4'b0100: begin
                sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
            end
            default: begin
                alu_res  = alu_a | alu_b;
                alu_cout = 1'b1;
            end
        endcase
        alu_zero = (alu_res == '0);
        alu_neg  = alu_res[WIDTH-1];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        op0 = 0; op1 = 0; cin0 = 0; cin1 = 0; s0 = 0; s1 = 0;
        #2;
        n_cmp++;
        if ({gnt0, gnt1, res_valid, res_id, err, flag_n, flag_z, flag_c, busy} !== 9'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {gnt0, gnt1, res_valid, res_id, err, flag_n, flag_z, flag_c, busy});
        end
        n_cmp++;
        if ({res, alu_a, alu_b} !== {3 * WIDTH{1'b0}}) begin
            n_mis++;
            $display("FAIL reset_data: got res=%h alu_a=%h alu_b=%h want 0", res, alu_a, alu_b);
        end
        tick();
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_single_add;
        req0 = 1; a0 = 5; b0 = 3; op0 = 4'b0100; cin0 = 0; s0 = 1;
        #1;
        n_cmp++;
        if ({gnt0, busy, alu_a} !== {1'b0, 1'b0, 32'd0}) begin
            n_mis++;
            $display("FAIL add_idle: got gnt0=%b busy=%b alu_a=%h want 0 0 0", gnt0, busy, alu_a);
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1, busy, alu_a, alu_b, alu_op} !== {3'b101, 32'd5, 32'd3, 4'b0100}) begin
            n_mis++;
            $display("FAIL add_exec: got gnt=%b%b busy=%b a=%h b=%h op=%h want 1 0 1 5 3 4",
                     gnt0, gnt1, busy, alu_a, alu_b, alu_op);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if ({res_valid, res, res_id, err, flag_n, flag_z, flag_c} !== {1'b1, 32'd8, 5'b00000})
        begin
            n_mis++;
            $display("FAIL add_done: got v=%b res=%h id=%b err=%b nzc=%b%b%b want 1 8 0 0 000",
                     res_valid, res, res_id, err, flag_n, flag_z, flag_c);
        end
        tick();
        n_cmp++;
        if ({res_valid, busy, gnt0, res} !== {3'b000, 32'd8}) begin
            n_mis++;
            $display("FAIL add_hold: got v=%b busy=%b gnt0=%b res=%h want 0 0 0 8",
                     res_valid, busy, gnt0, res);
        end
    endtask

    // Run straight after a reset so last_id is 1 and requester 0 takes the first tie.
    task automatic test_round_robin;
        rst = 1'b0;
        #2 rst = 1'b1;
        req0 = 1; a0 = 7; b0 = 7; op0 = 4'b0010; cin0 = 1; s0 = 1;
        req1 = 1; a1 = 1; b1 = 1; op1 = 4'b0100; cin1 = 0; s1 = 1;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_mis++;
            $display("FAIL rr_first_gnt: got %b%b want 10", gnt0, gnt1);
        end
        tick();
        n_cmp++;
        if ({res_valid, res, res_id, flag_n, flag_z, flag_c} !== {1'b1, 32'd0, 4'b0011}) begin
            n_mis++;
            $display("FAIL rr_first_res: got v=%b res=%h id=%b nzc=%b%b%b want 1 0 0 011",
                     res_valid, res, res_id, flag_n, flag_z, flag_c);
        end
        tick();
        n_cmp++;
        if ({busy, gnt0, gnt1} !== 3'b000) begin
            n_mis++;
            $display("FAIL rr_idle_gap: got busy=%b gnt=%b%b want 0 00", busy, gnt0, gnt1);
        end
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b01) begin
            n_mis++;
            $display("FAIL rr_second_gnt: got %b%b want 01", gnt0, gnt1);
        end
        tick();
        n_cmp++;
        if ({res_valid, res, res_id, flag_n, flag_z, flag_c} !== {1'b1, 32'd2, 4'b1000}) begin
            n_mis++;
            $display("FAIL rr_second_res: got v=%b res=%h id=%b nzc=%b%b%b want 1 2 1 000",
                     res_valid, res, res_id, flag_n, flag_z, flag_c);
        end
        tick();
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_mis++;
            $display("FAIL rr_third_gnt: got %b%b want 10", gnt0, gnt1);
        end
        req0 = 0; req1 = 0;
        tick();
        tick();
    endtask

    // Flags are N0 Z1 C1 from the final 7-7 of the round-robin test.
    task automatic test_sub_no_flags;
        req1 = 1; a1 = 0; b1 = 1; op1 = 4'b0010; cin1 = 1; s1 = 0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b01) begin
            n_mis++;
            $display("FAIL sub_gnt: got %b%b want 01", gnt0, gnt1);
        end
        req1 = 0;
        tick();
        n_cmp++;
        if ({res_valid, res, res_id, err} !== {1'b1, 32'hFFFF_FFFF, 2'b10}) begin
            n_mis++;
            $display("FAIL sub_res: got v=%b res=%h id=%b err=%b want 1 ffffffff 1 0",
                     res_valid, res, res_id, err);
        end
        n_cmp++;
        if ({flag_n, flag_z, flag_c} !== 3'b011) begin
            n_mis++;
            $display("FAIL sub_flags_kept: got %b%b%b want 011", flag_n, flag_z, flag_c);
        end
        tick();
    endtask

    task automatic test_invalid_op;
        req0 = 1; a0 = 3; b0 = 5; op0 = 4'b1111; cin0 = 0; s0 = 1;
        tick();
        n_cmp++;
        if ({gnt0, alu_op} !== {1'b1, 4'b1111}) begin
            n_mis++;
            $display("FAIL inv_exec: got gnt0=%b op=%h want 1 f", gnt0, alu_op);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if ({res_valid, err, res, res_id, flag_n, flag_z, flag_c} !== {2'b11, 32'd0, 4'b0011})
        begin
            n_mis++;
            $display("FAIL inv_done: got v=%b err=%b res=%h id=%b nzc=%b%b%b want 1 1 0 0 011",
                     res_valid, err, res, res_id, flag_n, flag_z, flag_c);
        end
        tick();
        n_cmp++;
        if ({res_valid, err} !== 2'b01) begin
            n_mis++;
            $display("FAIL inv_hold: got v=%b err=%b want 0 1", res_valid, err);
        end
    endtask

    task automatic test_operand_change;
        req0 = 1; a0 = 100; b0 = 1; op0 = 4'b0100; cin0 = 0; s0 = 1;
        tick();
        n_cmp++;
        if (alu_a !== 32'd100) begin
            n_mis++;
            $display("FAIL chg_exec: got alu_a=%h want 64", alu_a);
        end
        a0 = 200; req0 = 0;
        #1;
        n_cmp++;
        if (alu_a !== 32'd100) begin
            n_mis++;
            $display("FAIL chg_exec_after: got alu_a=%h want 64", alu_a);
        end
        tick();
        n_cmp++;
        if ({res_valid, res, err, flag_n, flag_z, flag_c} !== {1'b1, 32'd101, 4'b0000}) begin
            n_mis++;
            $display("FAIL chg_done: got v=%b res=%h err=%b nzc=%b%b%b want 1 65 0 000",
                     res_valid, res, err, flag_n, flag_z, flag_c);
        end
        tick();
    endtask

    task automatic test_reset_abort;
        int seen;
        req0 = 1; a0 = 2; b0 = 2; op0 = 4'b0100; cin0 = 0; s0 = 1;
        tick();
        n_cmp++;
        if (gnt0 !== 1'b1) begin
            n_mis++;
            $display("FAIL abort_exec: got gnt0=%b want 1", gnt0);
        end
        rst = 1'b0;
        req0 = 0;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, busy, res_valid, res, err, flag_n, flag_z, flag_c, alu_a} !==
            {4'b0000, 32'd0, 4'b0000, 32'd0}) begin
            n_mis++;
            $display("FAIL abort_async: got gnt=%b%b busy=%b v=%b res=%h err=%b nzc=%b%b%b a=%h",
                     gnt0, gnt1, busy, res_valid, res, err, flag_n, flag_z, flag_c, alu_a);
        end
        tick();
        #2 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (res_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_mis++;
            $display("FAIL abort_no_valid: got %0d pulses want 0", seen);
        end
        req0 = 1; a0 = 10; b0 = 20; op0 = 4'b0100; cin0 = 0; s0 = 1;
        tick();
        n_cmp++;
        if ({gnt0, alu_a} !== {1'b1, 32'd10}) begin
            n_mis++;
            $display("FAIL post_rst_gnt: got gnt0=%b a=%h want 1 a", gnt0, alu_a);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if ({res_valid, res, res_id, flag_n, flag_z, flag_c} !== {1'b1, 32'd30, 4'b0000}) begin
            n_mis++;
            $display("FAIL post_rst_res: got v=%b res=%h id=%b nzc=%b%b%b want 1 1e 0 000",
                     res_valid, res, res_id, flag_n, flag_z, flag_c);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_sub_no_flags();
        test_invalid_op();
        test_operand_change();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
